// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared channel count and channel-index type for the round-robin arbiter
package rr_arb_pkg;
  localparam int N_CH = 4;
  typedef logic [1:0] ch_idx_t;
endpackage

// File: rtl/rr_pick_4.sv
// rr_pick_4: round-robin pick starting after last; ports req/last in, idx/any out
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  ch_idx_t         last,
  output ch_idx_t         idx,
  output logic            any
);
  always_comb begin
    any = |req;
    idx = last;
    for (int k = N_CH; k >= 1; k--) if (req[last + 2'(k)]) idx = last + 2'(k);
  end
endmodule

// File: rtl/rr_arb_mux_4_1.sv
// rr_arb_mux_4_1: 4-channel round-robin arbiter into a registered output slot; ports clk/rst_n, in_valid/in_ready/d0-d3 in, out_valid/out_ready/out_data/out_sel out
module rr_arb_mux_4_1
  import rr_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in_valid,
  output logic [N_CH-1:0] in_ready,
  input  logic [W-1:0]    d0,
  input  logic [W-1:0]    d1,
  input  logic [W-1:0]    d2,
  input  logic [W-1:0]    d3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output ch_idx_t         out_sel
);
  ch_idx_t      last_grant;
  ch_idx_t      gnt_idx;
  logic         any_req;
  logic         xfer;
  logic [W-1:0] sel_d;
  rr_pick_4 u_pick (
    .req  (in_valid),
    .last (last_grant),
    .idx  (gnt_idx),
    .any  (any_req)
  );
  assign xfer     = rst_n & (~out_valid | out_ready) & any_req;
  assign in_ready = {N_CH{xfer}} & (N_CH'(1) << gnt_idx);
  always_comb begin
    sel_d = d0;
    case (gnt_idx)
      2'd0: sel_d = d0;
      2'd1: sel_d = d1;
      2'd2: sel_d = d2;
      2'd3: sel_d = d3;
      default: sel_d = d0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= 2'd3;
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_data   <= sel_d;
      out_sel    <= gnt_idx;
      last_grant <= gnt_idx;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// tb_rr_arb_mux_4_1: directed self-checking bench for rr_arb_mux_4_1
module tb_rr_arb_mux_4_1;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [3:0] d0, d1, d2, d3;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  int tests = 0;
  int fails = 0;
  rr_arb_mux_4_1 #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );
  always #5 clk = ~clk;
  task automatic test_reset;
    rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    #1;
    tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready_low: got %b want 0000", in_ready); end
    @(posedge clk); @(negedge clk);
    in_valid = 4'b0000; out_ready = 1'b0; rst_n = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    tests++; if (out_sel !== 2'd0) begin fails++; $display("FAIL reset_out_sel: got %0d want 0", out_sel); end
    tests++; if (out_data !== 4'h0) begin fails++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
    @(negedge clk);
  endtask
  task automatic test_rotate;
    logic [3:0] e;
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = 4'b0001 << (i % 4);
      #1;
      tests++; if (in_ready !== e) begin fails++; $display("FAIL rotate_in_ready[%0d]: got %b want %b", i, in_ready, e); end
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rotate_valid[%0d]: got %b want 1", i, out_valid); end
      tests++; if (out_sel !== 2'(i % 4)) begin fails++; $display("FAIL rotate_sel[%0d]: got %0d want %0d", i, out_sel, i % 4); end
      tests++; if (out_data !== 4'(i % 4 + 1)) begin fails++; $display("FAIL rotate_data[%0d]: got %h want %h", i, out_data, i % 4 + 1); end
      @(negedge clk);
    end
    in_valid = 4'b0000;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rotate_drain: got %b want 0", out_valid); end
    @(negedge clk);
  endtask
  task automatic test_single;
    in_valid = 4'b0100; d2 = 4'hA; out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL single_in_ready: got %b want 0100", in_ready); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", out_valid); end
    tests++; if (out_sel !== 2'd2) begin fails++; $display("FAIL single_sel: got %0d want 2", out_sel); end
    tests++; if (out_data !== 4'hA) begin fails++; $display("FAIL single_data: got %h want a", out_data); end
    @(negedge clk);
    in_valid = 4'b0000;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drain_valid: got %b want 0", out_valid); end
    tests++; if (out_data !== 4'hA) begin fails++; $display("FAIL single_drain_data_hold: got %h want a", out_data); end
    @(negedge clk);
  endtask
  task automatic test_backpressure;
    in_valid = 4'b0100; d2 = 4'h3; out_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (out_data !== 4'h3) begin fails++; $display("FAIL bp_load_data: got %h want 3", out_data); end
    @(negedge clk);
    out_ready = 1'b0; in_valid = 4'b1111;
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h7; d3 = 4'h4;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", i, in_ready); end
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
      tests++; if (out_data !== 4'h3) begin fails++; $display("FAIL bp_data[%0d]: got %h want 3", i, out_data); end
      tests++; if (out_sel !== 2'd2) begin fails++; $display("FAIL bp_sel[%0d]: got %0d want 2", i, out_sel); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 4'b1000) begin fails++; $display("FAIL bp_resume_in_ready: got %b want 1000", in_ready); end
    @(posedge clk); #1;
    tests++; if (out_sel !== 2'd3) begin fails++; $display("FAIL bp_resume_sel: got %0d want 3", out_sel); end
    tests++; if (out_data !== 4'h4) begin fails++; $display("FAIL bp_resume_data: got %h want 4", out_data); end
    @(negedge clk);
  endtask
  task automatic test_sparse;
    in_valid = 4'b0001; d0 = 4'h9; d3 = 4'hC; out_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (out_sel !== 2'd0) begin fails++; $display("FAIL sparse_setup_sel: got %0d want 0", out_sel); end
    @(negedge clk);
    in_valid = 4'b1001;
    #1;
    tests++; if (in_ready !== 4'b1000) begin fails++; $display("FAIL sparse_first_ready: got %b want 1000", in_ready); end
    @(posedge clk); #1;
    tests++; if (out_sel !== 2'd3) begin fails++; $display("FAIL sparse_first_sel: got %0d want 3", out_sel); end
    tests++; if (out_data !== 4'hC) begin fails++; $display("FAIL sparse_first_data: got %h want c", out_data); end
    @(negedge clk);
    #1;
    tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL sparse_second_ready: got %b want 0001", in_ready); end
    @(posedge clk); #1;
    tests++; if (out_sel !== 2'd0) begin fails++; $display("FAIL sparse_second_sel: got %0d want 0", out_sel); end
    tests++; if (out_data !== 4'h9) begin fails++; $display("FAIL sparse_second_data: got %h want 9", out_data); end
    @(negedge clk);
    in_valid = 4'b0000;
    @(posedge clk); @(negedge clk);
  endtask
  task automatic test_reset_mid;
    in_valid = 4'b0010; d1 = 4'h5; out_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_setup_valid: got %b want 1", out_valid); end
    @(negedge clk);
    in_valid = 4'b0000; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_async_valid: got %b want 0", out_valid); end
    tests++; if (out_data !== 4'h0) begin fails++; $display("FAIL mid_async_data: got %h want 0", out_data); end
    @(negedge clk);
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    in_valid = 4'b0110; out_ready = 1'b1; rst_n = 1'b1;
    #1;
    tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL mid_release_ready: got %b want 0010", in_ready); end
    @(posedge clk); #1;
    tests++; if (out_sel !== 2'd1) begin fails++; $display("FAIL mid_release_sel: got %0d want 1", out_sel); end
    tests++; if (out_data !== 4'h2) begin fails++; $display("FAIL mid_release_data: got %h want 2", out_data); end
    @(negedge clk);
    in_valid = 4'b0000;
  endtask
  initial begin
    test_reset;
    test_rotate;
    test_single;
    test_backpressure;
    test_sparse;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
